// File: rtl/step_rate_ctrl_if.sv
// Command/strobe bundle between a motion command source and step_rate_ctrl.
// The command source is the master; the step generator is the slave.
interface step_rate_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
);
    logic             START;
    logic             ABORT;
    logic             DIR_IN;
    logic [CNT_W-1:0] STEPS;
    logic [PER_W-1:0] PERIOD;
    logic             STEP;
    logic             TOG;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] REMAIN;

    modport master (
        output START, ABORT, DIR_IN, STEPS, PERIOD,
        input  STEP, TOG, BUSY, DONE, REMAIN
    );

    modport slave (
        input  START, ABORT, DIR_IN, STEPS, PERIOD,
        output STEP, TOG, BUSY, DONE, REMAIN
    );
endinterface

// File: rtl/step_rate_ctrl.sv
// Move command -> one-cycle STEP strobe train with latched direction TOG.
// Optional acceleration ramp enabled by defining STEP_RATE_RAMP_EN.
module step_rate_ctrl #(
    parameter int CNT_W      = 16,
    parameter int PER_W      = 16,
    parameter int RAMP_SHIFT = 3
) (
    input logic              CLK,
    input logic              RST,
    step_rate_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    if (RAMP_SHIFT < 0 || RAMP_SHIFT >= PER_W) begin : g_bad_shift
        $error("RAMP_SHIFT must lie in 0..PER_W-1");
    end

    state_t           state_reg, state_next;
    logic [PER_W-1:0] cnt_reg, cnt_next;
    logic [PER_W-1:0] per_reg, per_next;
    logic [CNT_W-1:0] remain_reg, remain_next;
    logic             step_reg, step_next;
    logic             tog_reg, tog_next;
    logic             done_reg, done_next;
    logic [PER_W-1:0] eff_per;
    logic [PER_W-1:0] first_int;
    logic [PER_W-1:0] reload_int;

    // Periods of 0 or 1 would leave no idle cycle between strobes.
    assign eff_per = (bus.PERIOD < PER_W'(2)) ? PER_W'(2) : bus.PERIOD;

`ifdef STEP_RATE_RAMP_EN
    localparam logic [PER_W+1:0] PER_MAX = {2'b00, {PER_W{1'b1}}};
    logic [PER_W-1:0] cur_reg, cur_next;
    logic [PER_W+1:0] per_x4;
    logic [PER_W-1:0] dec;
    logic [PER_W-1:0] cur_after_step;

    assign per_x4         = {eff_per, 2'b00};
    assign first_int      = (per_x4 > PER_MAX) ? {PER_W{1'b1}} : per_x4[PER_W-1:0];
    assign dec            = ((cur_reg >> RAMP_SHIFT) == '0) ? PER_W'(1) : (cur_reg >> RAMP_SHIFT);
    assign cur_after_step = ((cur_reg - per_reg) <= dec) ? per_reg : (cur_reg - dec);
    assign reload_int     = cur_reg;
`else
    assign first_int      = eff_per;
    assign reload_int     = per_reg;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            per_reg    <= '0;
            remain_reg <= '0;
            step_reg   <= 1'b0;
            tog_reg    <= 1'b0;
            done_reg   <= 1'b0;
`ifdef STEP_RATE_RAMP_EN
            cur_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            per_reg    <= per_next;
            remain_reg <= remain_next;
            step_reg   <= step_next;
            tog_reg    <= tog_next;
            done_reg   <= done_next;
`ifdef STEP_RATE_RAMP_EN
            cur_reg    <= cur_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        per_next    = per_reg;
        remain_next = remain_reg;
        step_next   = 1'b0;
        tog_next    = tog_reg;
        done_next   = 1'b0;
`ifdef STEP_RATE_RAMP_EN
        cur_next    = cur_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.START) begin
                    if (bus.STEPS != '0) begin
                        state_next  = RUN;
                        remain_next = bus.STEPS;
                        tog_next    = bus.DIR_IN;
                        per_next    = eff_per;
                        cnt_next    = first_int - PER_W'(1);
`ifdef STEP_RATE_RAMP_EN
                        cur_next    = first_int;
`endif
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.ABORT) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (cnt_reg == '0) begin
                    // Current cycle carries a strobe; leave once the last one is out.
                    if (remain_reg == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = reload_int - PER_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg - PER_W'(1);
                    if (cnt_reg == PER_W'(1)) begin
                        step_next = 1'b1;
                        if (remain_reg != '0) begin
                            remain_next = remain_reg - CNT_W'(1);
                        end
`ifdef STEP_RATE_RAMP_EN
                        cur_next = cur_after_step;
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.STEP   = step_reg;
    assign bus.TOG    = tog_reg;
    assign bus.BUSY   = (state_reg == RUN);
    assign bus.DONE   = done_reg;
    assign bus.REMAIN = remain_reg;
endmodule

// File: tb/tb_step_rate_ctrl.sv
// Self-checking bench for step_rate_ctrl: per-cycle comparison against a
// schedule-based model of strobe times (ramp schedule when STEP_RATE_RAMP_EN).
module tb_step_rate_ctrl;
    localparam int CNT_W = 16;
    localparam int PER_W = 16;
    localparam int RS    = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    step_rate_ctrl_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();

    step_rate_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W), .RAMP_SHIFT(RS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Model: absolute cycle numbers of each strobe and of DONE for the active move.
    bit m_active;
    bit m_step;
    bit m_done;
    bit m_tog;
    int m_remain;
    int m_taken;
    int m_done_t;
    int m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int first_interval(input int per);
        int p;
        p = (per < 2) ? 2 : per;
`ifdef STEP_RATE_RAMP_EN
        return (4 * p > (1 << PER_W) - 1) ? (1 << PER_W) - 1 : 4 * p;
`else
        return p;
`endif
    endfunction

    function automatic int next_interval(input int cur, input int per);
        int p;
        int d;
        p = (per < 2) ? 2 : per;
`ifdef STEP_RATE_RAMP_EN
        d = cur >> RS;
        if (d < 1) d = 1;
        return (cur - d < p) ? p : cur - d;
`else
        d = 0;
        return p + d;
`endif
    endfunction

    task automatic model_reset();
        m_active = 0; m_step = 0; m_done = 0; m_tog = 0;
        m_remain = 0; m_taken = 0; m_done_t = 0;
        m_q.delete();
    endtask

    task automatic model_edge();
        int t;
        int cur;
        m_step = 0;
        m_done = 0;
        if (!m_active) begin
            if (bus.START) begin
                if (bus.STEPS == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_remain = int'(bus.STEPS);
                    m_tog    = bus.DIR_IN;
                    m_taken  = 0;
                    m_q.delete();
                    t   = cyc;
                    cur = first_interval(int'(bus.PERIOD));
                    for (int i = 0; i < int'(bus.STEPS); i++) begin
                        t += cur;
                        m_q.push_back(t - 1);
                        cur = next_interval(cur, int'(bus.PERIOD));
                    end
                    m_done_t = t;
                end
            end
        end else if (bus.ABORT) begin
            m_active = 0;
            m_done   = 1;
        end else begin
            if (m_q.size() > 0 && m_q[0] == cyc) begin
                void'(m_q.pop_front());
                m_step = 1;
                m_remain--;
                m_taken++;
            end
            if (cyc == m_done_t) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("STEP",   32'(bus.STEP),   32'(m_step));
        chk("BUSY",   32'(bus.BUSY),   32'(m_active));
        chk("DONE",   32'(bus.DONE),   32'(m_done));
        chk("TOG",    32'(bus.TOG),    32'(m_tog));
        chk("REMAIN", 32'(bus.REMAIN), 32'(m_remain));
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_move(input int n, input int per, input bit dir,
                           input int abort_after, input bit noise);
        int  guard;
        bit  aborted;
        guard = 0;
        while (m_active && guard < 20000) begin
            tick();
            guard++;
        end
        bus.START  = 1'b1;
        bus.STEPS  = CNT_W'(n);
        bus.PERIOD = PER_W'(per);
        bus.DIR_IN = dir;
        tick();
        bus.START = 1'b0;
        aborted = 0;
        guard = 0;
        while (m_active && guard < 20000) begin
            if (noise) begin
                bus.START  = 1'($urandom_range(0, 1));
                bus.DIR_IN = 1'($urandom_range(0, 1));
                bus.STEPS  = CNT_W'($urandom_range(0, 50));
                bus.PERIOD = PER_W'($urandom_range(0, 20));
            end
            if (!aborted && abort_after >= 0 && m_taken == abort_after) begin
                bus.ABORT = 1'b1;
                aborted   = 1;
            end
            tick();
            bus.ABORT = 1'b0;
            guard++;
        end
        bus.START = 1'b0;
        checks++;
        assert (guard < 20000) else begin
            errors++;
            $error("FAIL move_timeout observed=%0d expected<%0d", guard, 20000);
        end
        tick();
    endtask

    initial begin
        bus.START = 0; bus.ABORT = 0; bus.DIR_IN = 0; bus.STEPS = '0; bus.PERIOD = '0;
        model_reset();
        #2;
        check_all();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Basic move, then steps=0 (DONE only, TOG kept), then min period.
        do_move(3, 5, 1'b1, -1, 1'b0);
        do_move(0, 7, 1'b0, -1, 1'b0);
        chk("zero_steps_tog", 32'(bus.TOG), 32'd1);
        do_move(2, 0, 1'b0, -1, 1'b0);
        do_move(2, 1, 1'b1, -1, 1'b0);

        // Abort after the 5th strobe leaves 95 untaken.
        do_move(100, 4, 1'b1, 5, 1'b0);
        chk("abort_remain", 32'(bus.REMAIN), 32'd95);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);

        // ABORT while idle has no effect.
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        tick();

        // START/DIR_IN/STEPS/PERIOD churn during RUN.
        do_move(6, 3, 1'b0, -1, 1'b1);

`ifdef STEP_RATE_RAMP_EN
        do_move(16, 8, 1'b1, -1, 1'b0);
`endif

        for (int i = 0; i < 25; i++) begin
            int n;
            n = $urandom_range(0, 12);
            do_move(n, $urandom_range(0, 9), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1,
                    1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a 10-step move.
        bus.START = 1'b1; bus.STEPS = 16'd10; bus.PERIOD = 16'd6; bus.DIR_IN = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_reset_busy", 32'(bus.BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        check_all();
        do_move(3, 2, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
